branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 24 ++
 rtl/branch_ras.sv | 47 ++++
 rtl/branch_predictor.sv | 123 ++++++++++++
 tb/tb_branch_predictor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: BTB entry type codes,
// saturating-counter constants and the resolved-branch type encoder.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BTB_COND = 2'd0,
        BTB_JMP  = 2'd1,
        BTB_CALL = 2'd2,
        BTB_RET  = 2'd3
    } btb_type_e;

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;

    function automatic btb_type_e btb_type_from_flags(input logic is_call,
                                                      input logic is_ret,
                                                      input logic is_jmp);
        if (is_call)     return BTB_CALL;
        else if (is_ret) return BTB_RET;
        else if (is_jmp) return BTB_JMP;
        else             return BTB_COND;
    endfunction

endpackage

// File: rtl/branch_ras.sv
// Return address stack: circular buffer with a saturating occupancy count,
// so pushes at full silently overwrite the oldest return address.
module branch_ras
    import branch_predictor_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [31:0]              push_value,
    output logic [31:0]              top_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      entries [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;

    // ptr names the next free slot; when full it also names the oldest entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH))
                count <= count + CNT_W'(1);
        end else if (pop && (count != '0)) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i)
            entries[ptr] <= push_value;
    end

    assign top_o   = entries[ptr - PTR_W'(1)];
    assign count_o = count;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters plus a return address stack;
// combinational lookup from fetch_pc_i, updates from resolved branches.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int NUM_BTB_ENTRIES = 16,
    parameter int NUM_RAS_ENTRIES = 8,
    parameter int ENABLE          = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_request_i,
    input  logic        branch_is_taken_i,
    input  logic        branch_is_not_taken_i,
    input  logic [31:0] branch_source_i,
    input  logic [31:0] branch_pc_i,
    input  logic        branch_is_call_i,
    input  logic        branch_is_ret_i,
    input  logic        branch_is_jmp_i,
    input  logic [31:0] fetch_pc_i,
    output logic [31:0] next_pc_o,
    output logic        next_taken_o
);

    localparam int IDX   = $clog2(NUM_BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;
    localparam int CNT_W = $clog2(NUM_RAS_ENTRIES) + 1;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic              btb_valid  [NUM_BTB_ENTRIES];
    logic [1:0]        btb_ctr    [NUM_BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag    [NUM_BTB_ENTRIES];
    logic [31:0]       btb_target [NUM_BTB_ENTRIES];
    btb_type_e         btb_type   [NUM_BTB_ENTRIES];

    logic [IDX-1:0]    fetch_idx, upd_idx;
    logic [TAG_W-1:0]  fetch_tag, upd_tag;
    logic              fetch_hit, upd_hit, pred_taken;
    logic              upd_taken, upd_not_taken;
    btb_type_e         upd_type;
    logic [31:0]       ras_top;
    logic [CNT_W-1:0]  ras_count;
    logic [31:0]       fetch_pc_plus4;
    logic              unused_bits;

    assign unused_bits = &{1'b0, fetch_pc_i[1:0], branch_source_i[1:0]};

    assign fetch_idx = fetch_pc_i[IDX+1:2];
    assign fetch_tag = fetch_pc_i[31:IDX+2];
    assign upd_idx   = branch_source_i[IDX+1:2];
    assign upd_tag   = branch_source_i[31:IDX+2];

    assign fetch_hit = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
    assign upd_hit   = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

    assign upd_taken     = branch_request_i && branch_is_taken_i;
    assign upd_not_taken = branch_request_i && branch_is_not_taken_i;
    assign upd_type      = btb_type_from_flags(branch_is_call_i, branch_is_ret_i,
                                               branch_is_jmp_i);

    // Valid and counter fields carry the reset state; the rest is payload
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_ctr[i]   <= CTR_RESET;
            end
        end else if (upd_taken) begin
            if (upd_hit) begin
                btb_ctr[upd_idx] <= ctr_inc(btb_ctr[upd_idx]);
            end else begin
                btb_valid[upd_idx] <= 1'b1;
                btb_ctr[upd_idx]   <= CTR_ALLOC;
            end
        end else if (upd_not_taken && upd_hit) begin
            btb_ctr[upd_idx] <= ctr_dec(btb_ctr[upd_idx]);
        end
    end

    // Tag is rewritten on a hit too; it is unchanged then, which keeps the enable simple
    always_ff @(posedge clk_i) begin
        if (upd_taken && !rst_i) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= branch_pc_i;
            btb_type[upd_idx]   <= upd_type;
        end
    end

    branch_ras #(
        .DEPTH (NUM_RAS_ENTRIES)
    ) u_ras (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (branch_request_i && branch_is_call_i),
        .pop        (branch_request_i && branch_is_ret_i),
        .push_value (branch_source_i + 32'd4),
        .top_o      (ras_top),
        .count_o    (ras_count)
    );

    assign fetch_pc_plus4 = fetch_pc_i + 32'd4;
    assign pred_taken = (ENABLE != 0) && fetch_hit &&
                        ((btb_type[fetch_idx] != BTB_COND) || btb_ctr[fetch_idx][1]);

    always_comb begin
        next_taken_o = pred_taken;
        next_pc_o    = fetch_pc_plus4;
        if (pred_taken) begin
            if ((btb_type[fetch_idx] == BTB_RET) && (ras_count != '0))
                next_pc_o = ras_top;
            else
                next_pc_o = btb_target[fetch_idx];
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: table-driven BTB vectors plus hand-written RAS and
// reset sequences, expected values queued per step and compared on pop.
module tb_branch_predictor;

    localparam int K_NONE = 0, K_CT = 1, K_CN = 2, K_CALL = 3, K_RET = 4, K_JT = 5, K_JN = 6;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        branch_request_i, branch_is_taken_i, branch_is_not_taken_i;
    logic [31:0] branch_source_i, branch_pc_i, fetch_pc_i;
    logic        branch_is_call_i, branch_is_ret_i, branch_is_jmp_i;
    logic [31:0] next_pc_o, off_next_pc;
    logic        next_taken_o, off_next_taken;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] src;
        logic [31:0] pc;
        logic [31:0] fetch;
        logic        exp_taken;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        string       name;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] fetch;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    branch_predictor #(.NUM_BTB_ENTRIES(16), .NUM_RAS_ENTRIES(8), .ENABLE(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .branch_request_i(branch_request_i), .branch_is_taken_i(branch_is_taken_i),
        .branch_is_not_taken_i(branch_is_not_taken_i), .branch_source_i(branch_source_i),
        .branch_pc_i(branch_pc_i), .branch_is_call_i(branch_is_call_i),
        .branch_is_ret_i(branch_is_ret_i), .branch_is_jmp_i(branch_is_jmp_i),
        .fetch_pc_i(fetch_pc_i), .next_pc_o(next_pc_o), .next_taken_o(next_taken_o)
    );

    branch_predictor #(.NUM_BTB_ENTRIES(16), .NUM_RAS_ENTRIES(8), .ENABLE(0)) dut_off (
        .clk_i(clk_i), .rst_i(rst_i),
        .branch_request_i(branch_request_i), .branch_is_taken_i(branch_is_taken_i),
        .branch_is_not_taken_i(branch_is_not_taken_i), .branch_source_i(branch_source_i),
        .branch_pc_i(branch_pc_i), .branch_is_call_i(branch_is_call_i),
        .branch_is_ret_i(branch_is_ret_i), .branch_is_jmp_i(branch_is_jmp_i),
        .fetch_pc_i(fetch_pc_i), .next_pc_o(off_next_pc), .next_taken_o(off_next_taken)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int kind, input logic [31:0] src, input logic [31:0] pc,
                         input logic [31:0] fetch);
        branch_request_i      = (kind != K_NONE);
        branch_is_taken_i     = (kind == K_CT) || (kind == K_CALL) || (kind == K_RET) || (kind == K_JT);
        branch_is_not_taken_i = (kind == K_CN) || (kind == K_JN);
        branch_is_call_i      = (kind == K_CALL);
        branch_is_ret_i       = (kind == K_RET);
        branch_is_jmp_i       = (kind == K_JT) || (kind == K_JN);
        branch_source_i       = src;
        branch_pc_i           = pc;
        fetch_pc_i            = fetch;
    endtask

    task automatic step(input string n, input int kind, input logic [31:0] src,
                        input logic [31:0] pc, input logic [31:0] fetch,
                        input logic et, input logic [31:0] ep);
        exp_t e;
        @(negedge clk_i);
        drive(kind, src, pc, fetch);
        sb.push_back('{n, et, ep, fetch});
        #1;
        e = sb.pop_front();
        check({e.name, "_taken"}, {31'd0, next_taken_o}, {31'd0, e.taken});
        check({e.name, "_pc"}, next_pc_o, e.pc);
        check({e.name, "_off_taken"}, {31'd0, off_next_taken}, 32'd0);
        check({e.name, "_off_pc"}, off_next_pc, e.fetch + 32'd4);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(K_NONE, 32'h0, 32'h0, 32'h100);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    function automatic vec_t mk(string n, int kind, logic [31:0] src, logic [31:0] pc,
                                logic [31:0] fetch, logic et, logic [31:0] ep);
        vec_t v;
        v.name = n; v.kind = kind; v.src = src; v.pc = pc;
        v.fetch = fetch; v.exp_taken = et; v.exp_pc = ep;
        return v;
    endfunction

    initial begin
        logic [31:0] s;
        rst_i = 1'b1;
        drive(K_NONE, 32'h0, 32'h0, 32'h100);
        #3;
        check("in_reset_taken", {31'd0, next_taken_o}, 32'd0);
        check("in_reset_pc", next_pc_o, 32'h104);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Expectations are for the fetch in the same cycle (pre-update state)
        vecs.push_back(mk("reset_fetch",   K_NONE, 0, 0, 32'h100, 0, 32'h104));
        vecs.push_back(mk("cond_alloc",    K_CT, 32'h200, 32'h280, 32'h200, 0, 32'h204));
        vecs.push_back(mk("cond_hit",      K_NONE, 0, 0, 32'h200, 1, 32'h280));
        vecs.push_back(mk("nt1",           K_CN, 32'h200, 0, 32'h200, 1, 32'h280));
        vecs.push_back(mk("nt2",           K_CN, 32'h200, 0, 32'h200, 0, 32'h204));
        vecs.push_back(mk("after_nt2",     K_NONE, 0, 0, 32'h200, 0, 32'h204));
        vecs.push_back(mk("sat_t1",        K_CT, 32'h200, 32'h280, 32'h200, 0, 32'h204));
        vecs.push_back(mk("sat_t2",        K_CT, 32'h200, 32'h280, 32'h200, 0, 32'h204));
        vecs.push_back(mk("sat_t3",        K_CT, 32'h200, 32'h280, 32'h200, 1, 32'h280));
        vecs.push_back(mk("sat_t4",        K_CT, 32'h200, 32'h280, 32'h200, 1, 32'h280));
        vecs.push_back(mk("sat_nt",        K_CN, 32'h200, 0, 32'h200, 1, 32'h280));
        vecs.push_back(mk("sat_after",     K_NONE, 0, 0, 32'h200, 1, 32'h280));
        vecs.push_back(mk("same_cycle",    K_CT, 32'h400, 32'h500, 32'h400, 0, 32'h404));
        vecs.push_back(mk("next_cycle",    K_NONE, 0, 0, 32'h400, 1, 32'h500));
        vecs.push_back(mk("alias_a",       K_CT, 32'h40, 32'h1040, 32'h40, 0, 32'h44));
        vecs.push_back(mk("alias_b",       K_CT, 32'h80, 32'h2080, 32'h40, 1, 32'h1040));
        vecs.push_back(mk("alias_a_miss",  K_NONE, 0, 0, 32'h40, 0, 32'h44));
        vecs.push_back(mk("alias_b_hit",   K_NONE, 0, 0, 32'h80, 1, 32'h2080));
        vecs.push_back(mk("jmp_alloc",     K_JT, 32'h614, 32'h900, 32'h614, 0, 32'h618));
        vecs.push_back(mk("jmp_nt",        K_JN, 32'h614, 0, 32'h614, 1, 32'h900));
        vecs.push_back(mk("jmp_still",     K_NONE, 0, 0, 32'h614, 1, 32'h900));
        foreach (vecs[i])
            step(vecs[i].name, vecs[i].kind, vecs[i].src, vecs[i].pc, vecs[i].fetch,
                 vecs[i].exp_taken, vecs[i].exp_pc);

        // Call/return through the RAS
        do_reset();
        step("call1",    K_CALL, 32'h300, 32'h800, 32'h100, 0, 32'h104);
        step("ret1",     K_RET,  32'h810, 32'h304, 32'h810, 0, 32'h814);
        step("call2",    K_CALL, 32'h300, 32'h800, 32'h810, 1, 32'h304);
        step("ret_ras",  K_NONE, 0, 0, 32'h810, 1, 32'h304);
        step("call3",    K_CALL, 32'h900, 32'h800, 32'h300, 1, 32'h800);
        step("ret_ras3", K_NONE, 0, 0, 32'h810, 1, 32'h904);

        // RAS overflow then underflow
        do_reset();
        step("ret_empty", K_RET, 32'hA14, 32'h7000, 32'hA14, 0, 32'hA18);
        check("ras_cnt_empty", 32'(dut.u_ras.count_o), 32'd0);
        for (int i = 0; i < 9; i++)
            step($sformatf("push%0d", i), K_CALL, 32'h1000 + 32'(i) * 32'h40, 32'h8000, 32'hA14, 1,
                 (i == 0) ? 32'h7000 : 32'h1000 + 32'(i - 1) * 32'h40 + 32'h4);
        step("full_top", K_NONE, 0, 0, 32'hA14, 1, 32'h1000 + 32'd8 * 32'h40 + 32'h4);
        check("ras_cnt_full", 32'(dut.u_ras.count_o), 32'd8);
        for (int k = 1; k <= 9; k++) begin
            s = (k <= 8) ? 32'h1000 + 32'(9 - k) * 32'h40 + 32'h4 : 32'h7000;
            step($sformatf("pop%0d", k), K_RET, 32'hA14, 32'h7000, 32'hA14, 1, s);
            check($sformatf("ras_cnt_pop%0d", k), 32'(dut.u_ras.count_o), (k <= 8) ? 32'(9 - k) : 32'd0);
        end
        step("after_pops", K_NONE, 0, 0, 32'hA14, 1, 32'h7000);
        check("ras_cnt_final", 32'(dut.u_ras.count_o), 32'd0);

        // Asynchronous reset mid-cycle, with an update held during reset
        @(negedge clk_i);
        drive(K_NONE, 0, 0, 32'hA14);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_taken", {31'd0, next_taken_o}, 32'd0);
        check("async_rst_pc", next_pc_o, 32'hA18);
        drive(K_CT, 32'h700, 32'h123, 32'h700);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(K_NONE, 0, 0, 32'h700);
        step("rst_upd_dropped", K_NONE, 0, 0, 32'h700, 0, 32'h704);
        step("rst_cleared",     K_NONE, 0, 0, 32'hA14, 0, 32'hA18);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
